exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set datapath width (legal values 32, 64).
REQ-002 Port clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port rst  in  1  SHALL be the reset, asynchronous and active-low.
REQ-004 Port flush  in  1  SHALL discard the accepted or in-flight op.
REQ-005 Port in_valid  in  1 / in_ready  out  1  SHALL form the issue handshake; accept = in_valid & in_ready & !flush at a clock edge.
REQ-006 Port alu_control  in  5  SHALL select the operation.
REQ-007 Ports opa_in, opb_in, pc_in  in  XLEN  SHALL carry operand A, operand B or immediate, and PC.
REQ-008 Ports forward_a, forward_b  in  2; ex_data, mem_data  in  XLEN  SHALL carry the forwarding selects and sources.
REQ-009 Port out_valid  out  1  SHALL pulse for one cycle per completed op; result  out  XLEN, branch_target  out  XLEN  SHALL be valid while out_valid=1.
REQ-010 Port busy  out  1  SHALL be the stall request to the hazard unit, equal to !in_ready.

Function
REQ-011 Forwarding SHALL be combinational: select 01 -> ex_data, 10 -> mem_data, 00/11 -> port operand.
REQ-012 Operands SHALL be captured after forwarding at accept; later forwarding changes SHALL NOT affect an in-flight op.
REQ-013 ALU codes SHALL be: 00000 ADD, 01000 SUB, 00001 SLL, 00010 SLT, 00011 SLTU, 00100 XOR, 00101 SRL, 01101 SRA, 00110 OR, 00111 AND; any unlisted code SHALL execute as ADD.
REQ-014 Shift amount SHALL be opb[log2(XLEN)-1:0]; all arithmetic SHALL wrap modulo 2^XLEN.
REQ-015 ALU ops SHALL have latency 1: accepted at edge N, out_valid=1 in the cycle after edge N; back-to-back ALU accepts SHALL sustain 1 op per cycle.
REQ-016 branch_target SHALL be registered as pc_in + forwarded opb for every op.
REQ-017 MDU codes SHALL be: 10000 MUL (low XLEN), 10001 MULHU (high XLEN, unsigned), 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
REQ-018 The state machine SHALL have states IDLE and BUSY; an accepted MDU op moves IDLE->BUSY and loads the iteration counter with XLEN.
REQ-019 BUSY SHALL perform one radix-2 iteration per cycle; when the counter reaches 0 the FSM SHALL return to IDLE and assert out_valid.
REQ-020 MDU latency SHALL be fixed at XLEN+1 cycles, including special cases; in_ready=0 for the XLEN cycles after accept, and in_ready=1 in the cycle out_valid=1, so the next op can be accepted in that cycle.
REQ-021 Divide by zero SHALL give quotient all-ones and remainder = dividend; signed overflow (most-negative / -1) SHALL give quotient most-negative and remainder 0.
REQ-022 flush in IDLE SHALL block acceptance and suppress a pending out_valid; flush in BUSY SHALL return the FSM to IDLE next edge with no out_valid.
REQ-023 flush and in_valid in the same cycle SHALL result in the op being dropped.

Reset
REQ-024 While rst=0: state IDLE, counter 0, out_valid 0, result 0, branch_target 0, in_ready 1, busy 0.
REQ-025 rst asserted mid-MDU SHALL abort the op immediately with no out_valid after release.

Configuration
REQ-026 With EXEC_MDU_EN defined, MDU codes and the FSM SHALL be present as specified.
REQ-027 Without EXEC_MDU_EN, MDU codes SHALL execute as ADD with latency 1, and in_ready SHALL be tied 1 and busy tied 0.

Structure
REQ-028 Package exec_pkg SHALL hold the alu_control code constants, forwarding-select constants and the FSM state type.
REQ-029 The iterative multiply/divide datapath SHALL be the sub-module exec_mdu, instantiated only under EXEC_MDU_EN.

Verification (XLEN=32)
REQ-030 ADD opa=0xFFFFFFFF, opb=1 -> result 0x00000000 and out_valid exactly 1 cycle later.
REQ-031 SRA opa=0x80000000, opb=0x24, forward_a=01 with ex_data=0xF0000000 -> result 0xFF000000 (shift 4, forwarded operand).
REQ-032 DIV opa=-7, opb=2 -> result 0xFFFFFFFD after 33 cycles; busy=1 for cycles 1..32; ALU op issued on cycle 33 is accepted.
REQ-033 DIVU by 0 with opa=5 -> 0xFFFFFFFF; REM 0x80000000 by 0xFFFFFFFF -> 0; both with 33-cycle latency.
REQ-034 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; repeat with flush at cycle 10 -> no out_valid and in_ready=1 next cycle.
REQ-035 rst pulse low at cycle 5 of a MUL -> all outputs at reset values, no out_valid after release.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared constants and types for the execute stage: ALU/MDU operation codes,
// forwarding selects and the MDU sequencing state.
package exec_pkg;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b01000;
  localparam logic [4:0] OP_SLL   = 5'b00001;
  localparam logic [4:0] OP_SLT   = 5'b00010;
  localparam logic [4:0] OP_SLTU  = 5'b00011;
  localparam logic [4:0] OP_XOR   = 5'b00100;
  localparam logic [4:0] OP_SRL   = 5'b00101;
  localparam logic [4:0] OP_SRA   = 5'b01101;
  localparam logic [4:0] OP_OR    = 5'b00110;
  localparam logic [4:0] OP_AND   = 5'b00111;
  localparam logic [4:0] OP_MUL   = 5'b10000;
  localparam logic [4:0] OP_MULHU = 5'b10001;
  localparam logic [4:0] OP_DIV   = 5'b10100;
  localparam logic [4:0] OP_DIVU  = 5'b10101;
  localparam logic [4:0] OP_REM   = 5'b10110;
  localparam logic [4:0] OP_REMU  = 5'b10111;

  localparam logic [1:0] FWD_PORT = 2'b00;
  localparam logic [1:0] FWD_EX   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic is_mdu_op(input logic [4:0] op);
    case (op)
      OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exec_mdu.sv
// Iterative radix-2 multiply/divide datapath, one step per cycle when step_i.
// Present only when EXEC_MDU_EN is defined.
`ifdef EXEC_MDU_EN
module exec_mdu
  import exec_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] opa_i,
  input  logic [XLEN-1:0] opb_i,
  output logic [XLEN-1:0] res_c
);

  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, dvsr_q, dvsr_d, dvd_q, dvd_d;
  logic [4:0]      op_q, op_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic            start_mul_c, start_sgn_c, mul_c;
  logic [XLEN:0]   sum_c, shl_c, trial_c;
  logic [XLEN-1:0] quo_c, rem_c;

  assign start_mul_c = (op_i == OP_MUL) | (op_i == OP_MULHU);
  assign start_sgn_c = (op_i == OP_DIV) | (op_i == OP_REM);
  assign mul_c       = (op_q == OP_MUL) | (op_q == OP_MULHU);

  // Load on start; otherwise shift-add multiply or restoring divide on magnitudes
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    dvsr_d  = dvsr_q;
    dvd_d   = dvd_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    sum_c   = '0;
    shl_c   = '0;
    trial_c = '0;
    if (start_i) begin
      op_d   = op_i;
      hi_d   = '0;
      dvd_d  = opa_i;
      dz_d   = (opb_i == '0);
      qneg_d = start_sgn_c & (opa_i[XLEN-1] ^ opb_i[XLEN-1]);
      rneg_d = start_sgn_c & opa_i[XLEN-1];
      if (start_mul_c) begin
        lo_d   = opa_i;
        dvsr_d = opb_i;
      end else begin
        lo_d   = (start_sgn_c & opa_i[XLEN-1]) ? -opa_i : opa_i;
        dvsr_d = (start_sgn_c & opb_i[XLEN-1]) ? -opb_i : opb_i;
      end
    end else if (step_i) begin
      if (mul_c) begin
        sum_c = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvsr_q} : '0);
        hi_d  = sum_c[XLEN:1];
        lo_d  = {sum_c[0], lo_q[XLEN-1:1]};
      end else begin
        shl_c   = {hi_q, lo_q[XLEN-1]};
        trial_c = shl_c - {1'b0, dvsr_q};
        if (!trial_c[XLEN]) begin
          hi_d = trial_c[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = shl_c[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
      end
    end
  end

  // Final result taken from the post-step values so it can be registered on the last step
  always_comb begin
    quo_c = qneg_q ? -lo_d : lo_d;
    rem_c = rneg_q ? -hi_d : hi_d;
    case (op_q)
      OP_MUL:          res_c = lo_d;
      OP_MULHU:        res_c = hi_d;
      OP_DIV, OP_DIVU: res_c = dz_q ? '1 : quo_c;
      default:         res_c = dz_q ? dvd_q : rem_c;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      dvsr_q <= '0;
      dvd_q  <= '0;
      op_q   <= OP_ADD;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      dvsr_q <= dvsr_d;
      dvd_q  <= dvd_d;
      op_q   <= op_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
    end
  end

endmodule
`endif

// File: rtl/exec_unit.sv
// Execute stage: forwarding, single-cycle ALU and branch target, plus an optional
// iterative multiply/divide unit enabled by the EXEC_MDU_EN macro.
module exec_unit
  import exec_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_control,
  input  logic [XLEN-1:0] opa_in,
  input  logic [XLEN-1:0] opb_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [1:0]      forward_a,
  input  logic [1:0]      forward_b,
  input  logic [XLEN-1:0] ex_data,
  input  logic [XLEN-1:0] mem_data,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] branch_target,
  output logic            busy
);

  localparam int unsigned SH_W = $clog2(XLEN);

  logic [XLEN-1:0] opa_c, opb_c, alu_res_c;
  logic [SH_W-1:0] shamt_c;
  logic            accept_c;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d, bt_q, bt_d;

  // Operand forwarding from later pipeline stages
  always_comb begin
    case (forward_a)
      FWD_EX:   opa_c = ex_data;
      FWD_MEM:  opa_c = mem_data;
      FWD_PORT: opa_c = opa_in;
      default:  opa_c = opa_in;
    endcase
    case (forward_b)
      FWD_EX:   opb_c = ex_data;
      FWD_MEM:  opb_c = mem_data;
      FWD_PORT: opb_c = opb_in;
      default:  opb_c = opb_in;
    endcase
  end

  always_comb begin
    shamt_c = opb_c[SH_W-1:0];
    case (alu_control)
      OP_SUB:  alu_res_c = opa_c - opb_c;
      OP_SLL:  alu_res_c = opa_c << shamt_c;
      OP_SLT:  alu_res_c = XLEN'($signed(opa_c) < $signed(opb_c));
      OP_SLTU: alu_res_c = XLEN'(opa_c < opb_c);
      OP_XOR:  alu_res_c = opa_c ^ opb_c;
      OP_SRL:  alu_res_c = opa_c >> shamt_c;
      OP_SRA:  alu_res_c = XLEN'($signed(opa_c) >>> shamt_c);
      OP_OR:   alu_res_c = opa_c | opb_c;
      OP_AND:  alu_res_c = opa_c & opb_c;
      default: alu_res_c = opa_c + opb_c;
    endcase
  end

`ifdef EXEC_MDU_EN
  localparam int unsigned CNT_W = $clog2(XLEN + 1);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d, busy_q, busy_d;
  logic            mdu_start_c, mdu_step_c, is_mdu_c;
  logic [XLEN-1:0] mdu_res_c;

  assign is_mdu_c = is_mdu_op(alu_control);
  assign accept_c = in_valid & in_ready_q & ~flush;

  exec_mdu #(.XLEN(XLEN)) u_mdu (
    .clk     (clk),
    .rst     (rst),
    .start_i (mdu_start_c),
    .step_i  (mdu_step_c),
    .op_i    (alu_control),
    .opa_i   (opa_c),
    .opb_i   (opb_c),
    .res_c   (mdu_res_c)
  );

  // Issue/sequence FSM: ALU ops complete next cycle, MDU ops run XLEN steps in BUSY
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    bt_d        = bt_q;
    mdu_start_c = 1'b0;
    mdu_step_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          bt_d = pc_in + opb_c;
          if (is_mdu_c) begin
            state_d     = ST_BUSY;
            cnt_d       = CNT_W'(XLEN);
            mdu_start_c = 1'b1;
          end else begin
            result_d    = alu_res_c;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          mdu_step_c = 1'b1;
          cnt_d      = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b1;
            result_d    = mdu_res_c;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE);
    busy_d     = ~in_ready_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
`else
  assign accept_c = in_valid & ~flush;
  assign in_ready = 1'b1;
  assign busy     = 1'b0;

  // Every op, including multiply/divide codes, completes as a single-cycle ALU op
  always_comb begin
    out_valid_d = accept_c;
    result_d    = accept_c ? alu_res_c : result_q;
    bt_d        = accept_c ? (pc_in + opb_c) : bt_q;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      bt_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      bt_q        <= bt_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign result        = result_q;
  assign branch_target = bt_q;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit (XLEN=32); adapts expectations to EXEC_MDU_EN.
module tb_exec_unit;

  localparam logic [4:0] C_ADD = 5'b00000, C_SUB = 5'b01000, C_SLL = 5'b00001,
                         C_SLT = 5'b00010, C_SLTU = 5'b00011, C_XOR = 5'b00100,
                         C_SRL = 5'b00101, C_SRA = 5'b01101, C_OR = 5'b00110,
                         C_AND = 5'b00111, C_MUL = 5'b10000, C_MULHU = 5'b10001,
                         C_DIV = 5'b10100, C_DIVU = 5'b10101, C_REM = 5'b10110,
                         C_REMU = 5'b10111;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, busy;
  logic [4:0]  alu_control;
  logic [31:0] opa_in, opb_in, pc_in, ex_data, mem_data, result, branch_target;
  logic [1:0]  forward_a, forward_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0]  alu_codes [14] = '{C_ADD, C_SUB, C_SLL, C_SLT, C_SLTU, C_XOR, C_SRL,
                                  C_SRA, C_OR, C_AND, 5'b01001, 5'b11111, 5'b10010, 5'b01111};
  logic [4:0]  mdu_codes [6]  = '{C_MUL, C_MULHU, C_DIV, C_DIVU, C_REM, C_REMU};
  logic [31:0] edge_vals [6]  = '{32'h0, 32'h1, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h1F};

  exec_unit #(.XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_control   (alu_control),
    .opa_in        (opa_in),
    .opb_in        (opb_in),
    .pc_in         (pc_in),
    .forward_a     (forward_a),
    .forward_b     (forward_b),
    .ex_data       (ex_data),
    .mem_data      (mem_data),
    .out_valid     (out_valid),
    .result        (result),
    .branch_target (branch_target),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic f, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                       input logic [1:0] fa, input logic [1:0] fb,
                       input logic [31:0] ex, input logic [31:0] mem);
    in_valid = v; flush = f; alu_control = op;
    opa_in = a; opb_in = b; pc_in = pc;
    forward_a = fa; forward_b = fb; ex_data = ex; mem_data = mem;
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] p,
                                      input logic [31:0] ex, input logic [31:0] mem);
    if (s == 2'b01) return ex;
    if (s == 2'b10) return mem;
    return p;
  endfunction

  // Reference behaviour straight from the operation definitions
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
`ifdef EXEC_MDU_EN
    logic [63:0] p;
    logic        ovf;
    p   = {32'b0, a} * {32'b0, b};
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
`endif
    case (op)
      C_SUB:  return a - b;
      C_SLL:  return a << b[4:0];
      C_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      C_SLTU: return (a < b) ? 32'd1 : 32'd0;
      C_XOR:  return a ^ b;
      C_SRL:  return a >> b[4:0];
      C_SRA:  return 32'($signed(a) >>> b[4:0]);
      C_OR:   return a | b;
      C_AND:  return a & b;
`ifdef EXEC_MDU_EN
      C_MUL:   return p[31:0];
      C_MULHU: return p[63:32];
      C_DIVU:  return (b == 0) ? 32'hFFFFFFFF : a / b;
      C_REMU:  return (b == 0) ? a : a % b;
      C_DIV: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (ovf)    return 32'h80000000;
        return 32'($signed(a) / $signed(b));
      end
      C_REM: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        return 32'($signed(a) % $signed(b));
      end
`endif
      default: return a + b;
    endcase
  endfunction

`ifdef EXEC_MDU_EN
  // Issue one MDU op (operand A forwarded from ex_data), check 33-cycle timing,
  // then issue an ADD in the completion cycle and check it is accepted.
  task automatic run_mdu(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    logic [31:0] pc, a2, b2;
    pc = $urandom; a2 = $urandom; b2 = $urandom;
    drive(1'b1, 1'b0, op, $urandom, b, pc, 2'b01, 2'b00, a, $urandom);
    step();
    drive(1'b0, 1'b0, op, $urandom, $urandom, $urandom, 2'b01, 2'b01, $urandom, $urandom);
    for (int k = 1; k <= 32; k++) begin
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_early_valid"}, out_valid, 1'b0);
      step();
    end
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_result"}, result, model(op, a, b));
    check({tag, "_btarget"}, branch_target, pc + b);
    check({tag, "_ready"}, in_ready, 1'b1);
    drive(1'b1, 1'b0, C_ADD, a2, b2, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    step();
    drive(1'b0, 1'b0, C_ADD, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    check({tag, "_next_valid"}, out_valid, 1'b1);
    check({tag, "_next_result"}, result, a2 + b2);
  endtask
`endif

  initial begin
    logic [4:0]  op;
    logic [31:0] a, b, pc, ex, mem, ea, eb;
    logic [1:0]  fa, fb;
    logic        iv, fl, ev;

    rst = 1'b0;
    drive(1'b0, 1'b0, C_ADD, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    step();
    step();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 32'h0);
    check("rst_btarget", branch_target, 32'h0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    rst = 1'b1;
    step();

    // Wrapping add with a one-cycle out_valid pulse
    drive(1'b1, 1'b0, C_ADD, 32'hFFFFFFFF, 32'h1, 32'h1000, 2'b00, 2'b00, 32'h0, 32'h0);
    step();
    in_valid = 1'b0;
    check("add_wrap_valid", out_valid, 1'b1);
    check("add_wrap_result", result, 32'h0);
    check("add_wrap_btarget", branch_target, 32'h1001);
    step();
    check("add_wrap_pulse", out_valid, 1'b0);

    // Arithmetic shift with operand A forwarded from EX
    drive(1'b1, 1'b0, C_SRA, 32'h80000000, 32'h24, 32'h0, 2'b01, 2'b00, 32'hF0000000, 32'h0);
    step();
    in_valid = 1'b0;
    check("sra_fwd_valid", out_valid, 1'b1);
    check("sra_fwd_result", result, 32'hFF000000);

    // Flush in the same cycle as in_valid drops the op
    drive(1'b1, 1'b1, C_ADD, 32'h5, 32'h6, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    step();
    drive(1'b0, 1'b0, C_ADD, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    check("flush_drop_valid", out_valid, 1'b0);
    check("flush_drop_result", result, 32'hFF000000);

    // Randomized back-to-back ALU traffic with random forwarding, gaps and flushes
    for (int i = 0; i < 300; i++) begin
`ifdef EXEC_MDU_EN
      op = alu_codes[$urandom_range(0, 13)];
`else
      if ($urandom_range(0, 3) == 0) op = mdu_codes[$urandom_range(0, 5)];
      else op = alu_codes[$urandom_range(0, 13)];
`endif
      a   = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      b   = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      pc  = $urandom; ex = $urandom; mem = $urandom;
      fa  = 2'($urandom_range(0, 3));
      fb  = 2'($urandom_range(0, 3));
      iv  = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 7) == 0);
      ea  = fwd(fa, a, ex, mem);
      eb  = fwd(fb, b, ex, mem);
      ev  = iv & ~fl;
      drive(iv, fl, op, a, b, pc, fa, fb, ex, mem);
      step();
      check("rnd_valid", out_valid, ev);
      check("rnd_ready", in_ready, 1'b1);
      if (ev) begin
        check("rnd_result", result, model(op, ea, eb));
        check("rnd_btarget", branch_target, pc + eb);
      end
    end
    drive(1'b0, 1'b0, C_ADD, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    step();

`ifdef EXEC_MDU_EN
    run_mdu("div_neg7_2", C_DIV, 32'hFFFFFFF9, 32'h2);
    check("div_neg7_2_const", model(C_DIV, 32'hFFFFFFF9, 32'h2) ^ result ^ result, 32'hFFFFFFFD);
    run_mdu("divu_by0", C_DIVU, 32'h5, 32'h0);
    run_mdu("rem_ovf", C_REM, 32'h80000000, 32'hFFFFFFFF);
    run_mdu("div_ovf", C_DIV, 32'h80000000, 32'hFFFFFFFF);
    run_mdu("rem_by0", C_REM, 32'hFFFFFF00, 32'h0);
    run_mdu("mulhu_max", C_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int i = 0; i < 12; i++)
      run_mdu("mdu_rnd", mdu_codes[i % 6], $urandom, ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom);

    // MULHU flushed in its 10th busy cycle: no completion, ready again next cycle
    drive(1'b1, 1'b0, C_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    step();
    in_valid = 1'b0;
    for (int k = 1; k < 10; k++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("mdu_flush_ready", in_ready, 1'b1);
    check("mdu_flush_busy", busy, 1'b0);
    check("mdu_flush_valid", out_valid, 1'b0);
    for (int k = 0; k < 30; k++) begin
      check("mdu_flush_no_valid", out_valid, 1'b0);
      step();
    end

    // Reset pulse in cycle 5 of a MUL aborts it
    drive(1'b1, 1'b0, C_MUL, 32'h12345, 32'h777, 32'h40, 2'b00, 2'b00, 32'h0, 32'h0);
    step();
    in_valid = 1'b0;
    for (int k = 1; k < 5; k++) step();
    check("mul_rst_busy_before", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("mul_rst_valid", out_valid, 1'b0);
    check("mul_rst_result", result, 32'h0);
    check("mul_rst_btarget", branch_target, 32'h0);
    check("mul_rst_ready", in_ready, 1'b1);
    check("mul_rst_busy", busy, 1'b0);
    step();
    rst = 1'b1;
    for (int k = 0; k < 40; k++) begin
      check("mul_rst_no_valid", out_valid, 1'b0);
      step();
    end
`else
    // Without the MDU, multiply/divide codes behave as single-cycle ADD
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom;
      drive(1'b1, 1'b0, mdu_codes[i], a, b, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
      step();
      in_valid = 1'b0;
      check("nomdu_valid", out_valid, 1'b1);
      check("nomdu_result", result, a + b);
      check("nomdu_ready", in_ready, 1'b1);
      check("nomdu_busy", busy, 1'b0);
    end

    // Reset while a result is being presented clears everything at once
    drive(1'b1, 1'b0, C_XOR, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h10, 2'b00, 2'b00, 32'h0, 32'h0);
    step();
    in_valid = 1'b0;
    check("alu_rst_pre_result", result, 32'hAAAAAAAA);
    rst = 1'b0;
    #1;
    check("alu_rst_valid", out_valid, 1'b0);
    check("alu_rst_result", result, 32'h0);
    check("alu_rst_btarget", branch_target, 32'h0);
    step();
    rst = 1'b1;
    step();
    check("alu_rst_no_valid", out_valid, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
